pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/redirect sequencer for the 5-stage core; sits between branch_unit, hazard sources and the PC/pipeline regs.

---
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect sequencer for the 5-stage core
module pipeline_hazard_ctrl #(
  parameter int          WORD_SIZE    = 32,
  parameter int          NUM_REGS     = 32,
  parameter int          REG_SEL      = $clog2(NUM_REGS),
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] TRAP_VECTOR  = 32'h100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_target,
  input  logic                 ex_busy,
  input  logic                 idex_mem_read,
  input  logic [REG_SEL-1:0]   idex_rd,
  input  logic [REG_SEL-1:0]   ifid_rs1,
  input  logic [REG_SEL-1:0]   ifid_rs2,
  input  logic                 ifid_use1,
  input  logic                 ifid_use2,
  input  logic                 imem_ready,
  input  logic                 trap_req,
  output logic                 stall_pc,
  output logic                 stall_ifid,
  output logic                 stall_idex,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 flush_exmem,
  output logic                 flush_memwb,
  output logic                 pc_load,
  output logic [WORD_SIZE-1:0] pc_load_value,
  output logic [15:0]          flush_events
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {BOOT, RUN, REDIR_WAIT, TRAP_DRAIN} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] pend_target;
  logic [DW-1:0]        drain_cnt;
  logic                 load_use;
  logic [15:0]          events_bumped;

  // Load in ID/EX feeding a source operand of the IF/ID instruction; x0 never hazards
  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((ifid_use1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_use2 && (ifid_rs2 == idex_rd)));

  assign events_bumped = (flush_events == 16'hFFFF) ? flush_events : flush_events + 16'd1;

  // Per-stage commands decoded from the current state and this cycle's requests
  always_comb begin
    stall_pc      = 1'b0;
    stall_ifid    = 1'b0;
    stall_idex    = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    flush_memwb   = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    case (state)
      BOOT: begin
        flush_ifid    = 1'b1;
        flush_idex    = 1'b1;
        flush_exmem   = 1'b1;
        flush_memwb   = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = WORD_SIZE'(RESET_VECTOR);
      end
      RUN: begin
        if (trap_req) begin
          stall_pc    = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else if (redirect_valid && !ex_busy) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (imem_ready) begin
            pc_load       = 1'b1;
            pc_load_value = redirect_target;
          end else begin
            stall_pc = 1'b1;
          end
        end else if (ex_busy) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else if (load_use) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
      REDIR_WAIT: begin
        if (trap_req) begin
          stall_pc    = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else begin
          // pc_load overrides the PC hold on the cycle fetch finally accepts
          stall_pc   = 1'b1;
          flush_ifid = 1'b1;
          if (imem_ready) begin
            pc_load       = 1'b1;
            pc_load_value = pend_target;
          end
        end
      end
      TRAP_DRAIN: begin
        stall_pc    = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
        if ((drain_cnt == '0) && imem_ready) begin
          pc_load       = 1'b1;
          pc_load_value = WORD_SIZE'(TRAP_VECTOR);
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, pending redirect PC, drain counter and event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pend_target  <= '0;
      drain_cnt    <= '0;
      flush_events <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (trap_req) begin
            drain_cnt    <= DW'(DRAIN_CYCLES - 1);
            flush_events <= events_bumped;
            state        <= TRAP_DRAIN;
          end else if (redirect_valid && !ex_busy) begin
            flush_events <= events_bumped;
            if (!imem_ready) begin
              pend_target <= redirect_target;
              state       <= REDIR_WAIT;
            end
          end
        end
        REDIR_WAIT: begin
          if (trap_req) begin
            drain_cnt    <= DW'(DRAIN_CYCLES - 1);
            flush_events <= events_bumped;
            state        <= TRAP_DRAIN;
          end else if (imem_ready) begin
            state <= RUN;
          end
        end
        TRAP_DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DW'(1);
          end else if (imem_ready) begin
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        ex_busy = 1'b0;
  logic        idex_mem_read = 1'b0;
  logic [4:0]  idex_rd = '0;
  logic [4:0]  ifid_rs1 = '0;
  logic [4:0]  ifid_rs2 = '0;
  logic        ifid_use1 = 1'b0;
  logic        ifid_use2 = 1'b0;
  logic        imem_ready = 1'b0;
  logic        trap_req = 1'b0;
  logic        stall_pc, stall_ifid, stall_idex;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic [15:0] flush_events;

  pipeline_hazard_ctrl #(
    .WORD_SIZE(32), .NUM_REGS(32), .DRAIN_CYCLES(DRAIN),
    .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ex_busy(ex_busy), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use1(ifid_use1), .ifid_use2(ifid_use2),
    .imem_ready(imem_ready), .trap_req(trap_req),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // ctrl bit order: stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, flush_memwb, pc_load
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] val;
    logic [15:0] ev;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;

  // Reference model: plain bookkeeping of what the core is doing
  bit          m_booting = 1'b1;
  bit          m_waiting = 1'b0;
  int          m_drain_left = -1;
  logic [31:0] m_pend = '0;
  int          m_events = 0;

  task automatic step(input logic rn, input logic rv, input logic [31:0] rt,
                      input logic eb, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic ir, input logic tr);
    exp_t        e;
    bit          n_booting, n_waiting;
    int          n_drain, n_events;
    logic [31:0] n_pend;
    bit sp, si, sx, fi, fx, fe, fw, pl;
    rst_n = rn; redirect_valid = rv; redirect_target = rt; ex_busy = eb;
    idex_mem_read = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
    ifid_use1 = u1; ifid_use2 = u2; imem_ready = ir; trap_req = tr;
    if (!rn) begin
      m_booting = 1'b1; m_waiting = 1'b0; m_drain_left = -1; m_pend = '0; m_events = 0;
    end
    {sp, si, sx, fi, fx, fe, fw, pl} = '0;
    e.val = '0;
    n_booting = m_booting; n_waiting = m_waiting; n_drain = m_drain_left;
    n_events = m_events; n_pend = m_pend;
    if (m_booting) begin
      {fi, fx, fe, fw, pl} = 5'b11111;
      n_booting = 1'b0;
    end else if (m_drain_left >= 0) begin
      {sp, fi, fx, fe} = 4'b1111;
      if (m_drain_left == 0 && ir) begin
        pl = 1; e.val = 32'h100; n_drain = -1;
      end else if (m_drain_left > 0) begin
        n_drain = m_drain_left - 1;
      end
    end else if (tr) begin
      {sp, fi, fx, fe} = 4'b1111;
      n_drain = DRAIN - 1; n_waiting = 1'b0;
      n_events = (m_events < 65535) ? m_events + 1 : 65535;
    end else if (m_waiting) begin
      sp = 1; fi = 1;
      if (ir) begin
        pl = 1; e.val = m_pend; n_waiting = 1'b0;
      end
    end else if (rv && !eb) begin
      fi = 1; fx = 1;
      n_events = (m_events < 65535) ? m_events + 1 : 65535;
      if (ir) begin
        pl = 1; e.val = rt;
      end else begin
        sp = 1; n_pend = rt; n_waiting = 1'b1;
      end
    end else if (eb) begin
      {sp, si, sx, fe} = 4'b1111;
    end else if (mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd))) begin
      {sp, si, fx} = 3'b111;
    end
    e.ctrl = {sp, si, sx, fi, fx, fe, fw, pl};
    e.ev   = 16'(m_events);
    e.cyc  = cycle;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    if (rn) begin
      m_booting = n_booting; m_waiting = n_waiting; m_drain_left = n_drain;
      m_events = n_events; m_pend = n_pend;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
             flush_exmem, flush_memwb, pc_load};
      n_checks += 3;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl cyc=%0d actual=%b required=%b", e.cyc, act, e.ctrl);
      end
      if (pc_load_value !== e.val) begin
        n_fail++;
        $display("FAIL pc_load_value cyc=%0d actual=%h required=%h", e.cyc, pc_load_value, e.val);
      end
      if (flush_events !== e.ev) begin
        n_fail++;
        $display("FAIL flush_events cyc=%0d actual=%0d required=%0d", e.cyc, flush_events, e.ev);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // reset held 3 cycles, then one BOOT cycle, then quiet RUN
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // redirect accepted immediately
    step(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // redirect held while fetch busy, then released
    step(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // load-use on rs2, then x0 destination which never hazards
    step(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 1, 0);
    // redirect behind multi-cycle EX op
    for (int i = 0; i < 4; i++) step(1, 1, 32'h200, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // trap while a redirect is pending, drain with fetch stalled at the end
    step(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h44, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // reset in the middle of a drain
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 400) != 0, ($urandom % 4) == 0, $urandom,
           ($urandom % 5) == 0, $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom % 4) != 0, ($urandom % 25) == 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
